// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered 8N1/8E1 framing on a clken bit tick.
// Optional even parity bit enabled by defining TX_PARITY_EN.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       fpga_power_good,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e        state_q, state_d;
  logic          tx_q, tx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitpos_q, bitpos_d;
  logic          stopcnt_q, stopcnt_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic empty, full_w, push, drop, pop;

  assign empty  = (count_q == '0);
  assign full_w = (count_q == DEPTH_C);
  assign push   = wr_en && !full_w;
  assign drop   = wr_en && full_w;

  always_comb begin
    pop       = 1'b0;
    state_d   = state_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    bitpos_d  = bitpos_q;
    stopcnt_d = stopcnt_q;
    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          tx_d     = shreg_q[0];
          bitpos_d = 3'd0;
          state_d  = DATA;
        end
        DATA: begin
          if (bitpos_q != 3'd7) begin
            tx_d     = shreg_q[bitpos_q + 3'd1];
            bitpos_d = bitpos_q + 3'd1;
          end else begin
`ifdef TX_PARITY_EN
            tx_d      = ^shreg_q;
            state_d   = PARITY;
`else
            tx_d      = 1'b1;
            stopcnt_d = 1'b0;
            state_d   = STOP;
`endif
          end
        end
        PARITY: begin
          tx_d      = 1'b1;
          stopcnt_d = 1'b0;
          state_d   = STOP;
        end
        STOP: begin
          tx_d = 1'b1;
          if (stopcnt_q != STOP_LAST) begin
            stopcnt_d = 1'b1;
          end else if (!empty) begin
            // back-to-back: next start bit follows the last stop bit
            pop     = 1'b1;
            shreg_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clock) begin
    if (!fpga_power_good) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bitpos_q   <= '0;
      stopcnt_q  <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      bitpos_q   <= bitpos_d;
      stopcnt_q  <= stopcnt_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  assign tx       = tx_q;
  assign full     = full_w;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame table plus corner sequences.
// Second instance uses STOP_BITS=2; expectations follow TX_PARITY_EN.
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic       clken;
  logic [7:0] din;
  logic       wr_en;
  logic       ovf_clr;
  logic       full, overflow, tx, tx_busy;
  logic       full2, overflow2, tx2, tx_busy2;

  int checks;
  int failures;

  uart_transmitter #(.FIFO_DEPTH(4), .STOP_BITS(1)) u_dut (
    .clock          (clk),
    .fpga_power_good(rst_n),
    .clken          (clken),
    .din            (din),
    .wr_en          (wr_en),
    .full           (full),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .tx             (tx),
    .tx_busy        (tx_busy)
  );

  uart_transmitter #(.FIFO_DEPTH(4), .STOP_BITS(2)) u_dut2 (
    .clock          (clk),
    .fpga_power_good(rst_n),
    .clken          (clken),
    .din            (din),
    .wr_en          (wr_en),
    .full           (full2),
    .overflow       (overflow2),
    .ovf_clr        (ovf_clr),
    .tx             (tx2),
    .tx_busy        (tx_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    string      body;
    string      par;
  } vec_t;

  vec_t tbl [5];

  function automatic string frame(vec_t v);
`ifdef TX_PARITY_EN
    return {v.body, v.par, "1"};
`else
    return {v.body, "1"};
`endif
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    clken = 1'b1;
    @(negedge clk);
    clken = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic wr(logic [7:0] b);
    din   = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(string exp, string nm);
    for (int i = 0; i < exp.len(); i++) begin
      tick();
      chk({nm, "_tx"}, 8'(tx), 8'(exp.getc(i) == 8'h31));
    end
    tick();
    chk({nm, "_busy_end"}, 8'(tx_busy), 8'd0);
    chk({nm, "_tx_idle"}, 8'(tx), 8'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    string s;
    checks   = 0;
    failures = 0;
    clken    = 1'b0;
    din      = 8'h00;
    wr_en    = 1'b0;
    ovf_clr  = 1'b0;

    tbl[0] = '{8'hA5, "010100101", "0"};
    tbl[1] = '{8'h07, "011100000", "1"};
    tbl[2] = '{8'hFF, "011111111", "0"};
    tbl[3] = '{8'h00, "000000000", "0"};
    tbl[4] = '{8'h3C, "000111100", "0"};

    rst_n = 1'b0;
    wr_en = 1'b1;
    clken = 1'b1;
    repeat (2) @(negedge clk);
    wr_en = 1'b0;
    clken = 1'b0;
    rst_n = 1'b1;
    chk("rst_tx", 8'(tx), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    chk("rst_busy", 8'(tx_busy), 8'd0);
    tick();
    chk("rst_no_frame", 8'(tx), 8'd1);

    for (int k = 0; k < 5; k++) begin
      wr(tbl[k].data);
      chk("pre_start_tx", 8'(tx), 8'd1);
      chk("pre_start_busy", 8'(tx_busy), 8'd1);
      run_frame(frame(tbl[k]), $sformatf("frame_%02h", tbl[k].data));
    end

    // write into empty FIFO on the same edge as an idle tick
    din   = 8'h3C;
    wr_en = 1'b1;
    clken = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    clken = 1'b0;
    chk("same_tick_tx", 8'(tx), 8'd1);
    chk("same_tick_busy", 8'(tx_busy), 8'd1);
    run_frame(frame(tbl[4]), "same_tick");

    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    s = {frame('{8'h11, "010001000", "0"}),
         frame('{8'h22, "001000100", "0"}),
         frame('{8'h33, "011001100", "0"})};
    run_frame(s, "b2b");

    wr(8'hA5);
    wr(8'h07);
    wr(8'hFF);
    chk("ovf_full3", 8'(full), 8'd0);
    wr(8'h00);
    chk("ovf_full4", 8'(full), 8'd1);
    chk("ovf_none", 8'(overflow), 8'd0);
    wr(8'h3C);
    chk("ovf_set", 8'(overflow), 8'd1);
    chk("ovf_full5", 8'(full), 8'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", 8'(overflow), 8'd0);
    din     = 8'h11;
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_prio", 8'(overflow), 8'd1);
    s = {frame(tbl[0]), frame(tbl[1]), frame(tbl[2]), frame(tbl[3])};
    run_frame(s, "ovf_drain");

    wr(8'hFF);
    wr(8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_tx", 8'(tx), 8'((i == 0) ? 0 : 1));
    end
    do_reset();
    chk("mid_rst_tx", 8'(tx), 8'd1);
    chk("mid_rst_busy", 8'(tx_busy), 8'd0);
    chk("mid_rst_full", 8'(full), 8'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_tx", 8'(tx), 8'd1);
    end
    chk("post_rst_busy", 8'(tx_busy), 8'd0);

    do_reset();
    wr(8'h00);
    s = frame(tbl[3]);
    s = {s, "1"};
    for (int i = 0; i < s.len(); i++) begin
      tick();
      chk("stop2_tx", 8'(tx2), 8'(s.getc(i) == 8'h31));
    end
    chk("stop2_busy_hold", 8'(tx_busy2), 8'd1);
    tick();
    chk("stop2_busy_end", 8'(tx_busy2), 8'd0);
    chk("stop2_tx_idle", 8'(tx2), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of transmit FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter STOP_BITS, default 1, SHALL set the number of stop-bit periods per frame; legal values are 1 or 2.
REQ-003 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 fpga_power_good  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 clken  in  1  SHALL be a one-cycle bit-period tick; one pulse equals one bit time on the line.
REQ-006 din  in  8  SHALL carry the byte to transmit; it is sampled when wr_en=1.
REQ-007 wr_en  in  1  SHALL request a push of din into the FIFO.
REQ-008 full  out  1  SHALL be 1 when the FIFO holds FIFO_DEPTH entries.
REQ-009 overflow  out  1  SHALL be a sticky flag set when a write is dropped.
REQ-010 ovf_clr  in  1  SHALL clear overflow.
REQ-011 tx  out  1  SHALL be the serial line, idle high, registered.
REQ-012 tx_busy  out  1  SHALL be 1 when the state is not IDLE or the FIFO is non-empty.

Function
REQ-013 Frame SHALL be: 1 start bit (0), then D0..D7 (LSB first), then an optional parity bit (REQ-030), then STOP_BITS stop bits (1).
REQ-014 States SHALL be IDLE, START, DATA, PARITY and STOP; any other encoding SHALL return to IDLE with tx=1.
REQ-015 All state transitions and all tx changes SHALL occur only in cycles where clken=1; tx SHALL hold between ticks.
REQ-016 IDLE: when clken=1 and the FIFO is non-empty (pre-cycle), the block SHALL pop the head into the shift register, set tx<=0 and go to START.
REQ-017 START: on clken the block SHALL set tx<=D0, set bitpos<=0 and go to DATA.
REQ-018 DATA: on clken with bitpos<7 the block SHALL set tx<=D[bitpos+1] and increment bitpos; with bitpos==7 it SHALL go to PARITY (macro defined) or STOP, driving the corresponding bit.
REQ-019 STOP: tx SHALL be 1 for STOP_BITS tick periods; on the final tick, if the FIFO is non-empty the block SHALL pop, set tx<=0 and go to START (back-to-back, no idle gap); otherwise it SHALL go to IDLE.
REQ-020 Write when not full SHALL store din at the tail in the same cycle; full and tx_busy SHALL reflect the write the next cycle.
REQ-021 Write when full SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop when not full SHALL leave the count unchanged and preserve order.
REQ-023 A write into an empty FIFO in the same cycle as an IDLE clken SHALL NOT start a frame that cycle; the frame SHALL start on the next clken.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-025 ovf_clr SHALL clear overflow; a simultaneous drop event SHALL take priority, leaving overflow=1.

Reset
REQ-026 When fpga_power_good=0 at a clock edge, the block SHALL set tx=1, full=0, overflow=0, tx_busy=0, state=IDLE, and the FIFO empty.
REQ-027 Reset SHALL dominate wr_en, clken and ovf_clr.
REQ-028 Reset mid-frame SHALL abort the frame and drive tx=1 from the next cycle; discarded FIFO contents SHALL NOT be transmitted.
REQ-029 After reset release, no frame SHALL start before the first clken that sees a non-empty FIFO.

Configuration
REQ-030 With TX_PARITY_EN defined, the block SHALL send an even-parity bit (XOR of D0..D7) in PARITY for one tick period between D7 and the stop bits.
REQ-031 Without TX_PARITY_EN, the PARITY state SHALL be unreachable and the frame SHALL be 9+STOP_BITS bit periods long.

Verification
REQ-032 Write 0xA5 with clken every 16 clocks -> tx per tick: 0,1,0,1,0,0,1,0,1,1; tx_busy falls after the stop bit.
REQ-033 With TX_PARITY_EN: write 0x07 -> parity bit 1 after D7; write 0xA5 -> parity bit 0.
REQ-034 Write 0x11,0x22,0x33 back-to-back -> three contiguous frames with no idle tick between the stop bit and the next start bit.
REQ-035 With FIFO_DEPTH=4 and clken held low: 5 writes -> full=1 after the 4th write, 5th write dropped, overflow=1; ovf_clr -> overflow=0.
REQ-036 Assert reset during D3 of 0xFF -> tx=1 the next cycle, FIFO empty, no further frames.
REQ-037 With STOP_BITS=2: write 0x00 -> start bit, 8 zeros, then tx=1 for 2 ticks before IDLE.
